// File: rtl/seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexed driver for a NUM_DIGITS-digit seven-segment display.
// A prescaler divides the clock into digit slots of DIV cycles; a digit
// index walks 0..NUM_DIGITS-1 and the selected nibble of the active buffer
// is decoded to segments. New display data is captured into a pending
// buffer and only promoted to the active buffer at the frame boundary, so
// a frame is never shown half old / half new.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digits (1..8)
//   DIV            clock cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW 1 inverts seg and dp at the pins
//   AN_ACTIVE_LOW  1 inverts an at the pins
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   scan enable; 0 freezes the scan and blanks the display
//   load       in   capture strobe for value / dp_in / blank_lz
//   value      in   4*NUM_DIGITS hex nibbles, nibble 0 = digit 0 (LSD)
//   dp_in      in   decimal point per digit
//   blank_lz   in   leading-zero suppression request
//   seg        out  segments, seg[0]=a .. seg[6]=g
//   dp         out  decimal point of the digit being shown
//   an         out  one-hot digit select
//   frame_done out  one-cycle pulse at the end of each full scan
// ---------------------------------------------------------------------------
module seven_segment_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  // -------------------------------------------------------------------------
  // Local parameters
  // -------------------------------------------------------------------------
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  // Pin polarity masks. The inactive level of each output equals its mask,
  // because the logical inactive value is all zeros before inversion.
  localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_INV  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // -------------------------------------------------------------------------
  // Hex to seven-segment decode, bit order g..a
  // -------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;

  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_blz;

  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic                    r_act_blz;

  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic                    w_tick;
  logic                    w_last;
  logic                    w_wrap;
  logic [IDX_W-1:0]        w_idx_next;

  logic [3:0]              w_nib;
  logic                    w_dp_cur;
  logic                    w_blank_cur;
  logic [6:0]              w_seg_cur;
  logic [NUM_DIGITS-1:0]   w_an_cur;

  // Slot tick, last-digit detect and frame wrap; all gated by enable so a
  // paused scanner never advances or reports a frame.
  always_comb begin
    w_tick = enable & (r_cnt == CNT_MAX);
    w_last = (r_idx == IDX_MAX);
    w_wrap = w_tick & w_last;
    if (w_last) begin
      w_idx_next = '0;
    end else begin
      w_idx_next = r_idx + IDX_W'(1);
    end
  end

  // Prescaler and digit index; both hold while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (enable) begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= w_idx_next;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_idx <= r_idx;
      end
    end else begin
      r_cnt <= r_cnt;
      r_idx <= r_idx;
    end
  end

  // Pending buffer captures on every load; the active buffer only changes on
  // the frame wrap. A load on the wrap edge itself bypasses the pending
  // buffer so the freshly loaded data is not delayed by a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_blz <= 1'b0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
      r_act_blz  <= 1'b0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_in;
        r_pend_blz <= blank_lz;
      end else begin
        r_pend_val <= r_pend_val;
        r_pend_dp  <= r_pend_dp;
        r_pend_blz <= r_pend_blz;
      end

      if (w_wrap) begin
        if (load) begin
          r_act_val <= value;
          r_act_dp  <= dp_in;
          r_act_blz <= blank_lz;
        end else begin
          r_act_val <= r_pend_val;
          r_act_dp  <= r_pend_dp;
          r_act_blz <= r_pend_blz;
        end
      end else begin
        r_act_val <= r_act_val;
        r_act_dp  <= r_act_dp;
        r_act_blz <= r_act_blz;
      end
    end
  end

  // Digit select, nibble mux and leading-zero blanking for the current index.
  // The scan runs from the most significant digit down so that w_zero_run
  // holds "this nibble and every higher nibble are zero" at each position.
  always_comb begin
    logic w_zero_run;
    w_zero_run  = 1'b1;
    w_nib       = 4'h0;
    w_dp_cur    = 1'b0;
    w_blank_cur = 1'b0;
    w_an_cur    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_act_val[4*k +: 4] == 4'h0);
      if (r_idx == IDX_W'(k)) begin
        w_nib       = r_act_val[4*k +: 4];
        w_dp_cur    = r_act_dp[k];
        w_an_cur[k] = 1'b1;
        // Digit 0 always shows, so a value of zero still reads "0".
        w_blank_cur = r_act_blz & w_zero_run & (k != 0);
      end else begin
        w_an_cur[k] = 1'b0;
      end
    end
    if (w_blank_cur) begin
      w_seg_cur = 7'h00;
    end else begin
      w_seg_cur = hex_to_seg(w_nib);
    end
  end

  // Output registers, polarity applied here so the pins come straight from
  // flops. While disabled every output sits at its inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_INV;
      r_dp         <= DP_INV;
      r_an         <= AN_INV;
      r_frame_done <= 1'b0;
    end else if (enable) begin
      r_seg        <= w_seg_cur ^ SEG_INV;
      r_dp         <= w_dp_cur ^ DP_INV;
      r_an         <= w_an_cur ^ AN_INV;
      r_frame_done <= w_wrap;
    end else begin
      r_seg        <= SEG_INV;
      r_dp         <= DP_INV;
      r_an         <= AN_INV;
      r_frame_done <= 1'b0;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, DIV=4 and
// active-high pins. A table of display vectors (value, dp, blank_lz and the
// hand-decoded segment codes per digit) is loaded one at a time and checked
// cycle by cycle over a full frame. Hand-written sequences cover mid-frame
// loads, a load on the wrap edge, an enable pause and a mid-frame reset.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int DV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dpv;
    logic            blz;
    logic [3:0][6:0] segs;   // expected seg code, index = digit
  } vec_t;

  vec_t vecs [8];
  vec_t vz;
  vec_t v1111;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS    (ND),
    .DIV           (DV),
    .SEG_ACTIVE_LOW(1'b0),
    .AN_ACTIVE_LOW (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  function automatic vec_t mk(input logic [15:0] val, input logic [3:0] dpv, input logic blz,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.val  = val;
    v.dpv  = dpv;
    v.blz  = blz;
    v.segs = {s3, s2, s1, s0};
    return v;
  endfunction

  // {an, seg, dp, frame_done}
  function automatic logic [12:0] outs();
    return {an, seg, dp, frame_done};
  endfunction

  function automatic logic [12:0] exp_digit(input vec_t v, input int d, input logic f);
    logic [3:0] a;
    a = 4'b0001 << d;
    return {a, v.segs[d], v.dpv[d], f};
  endfunction

  task automatic cmp(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {an,seg,dp,fd}=%h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    value    = v.val;
    dp_in    = v.dpv;
    blank_lz = v.blz;
    load     = 1'b1;
  endtask

  // Check one full frame; entered on the falling edge where frame_done of the
  // previous frame was seen (or right after reset release). Optionally
  // strobes load with nv after sample load_at.
  task automatic check_frame(input vec_t e, input string tag, input bit do_load,
                             input vec_t nv, input int load_at);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      cmp($sformatf("%s_c%0d", tag, j), outs(), exp_digit(e, j / 4, (j == 15)));
      if (do_load && j == load_at) drive(nv);
      if (do_load && j == load_at + 1) load = 1'b0;
    end
  endtask

  // Load v and wait (bounded) for the frame_done that makes it active.
  task automatic load_and_sync(input vec_t v, input string tag);
    bit found;
    found = 1'b0;
    drive(v);
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (frame_done === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s_sync: frame_done not seen within 40 cycles, expected a pulse", tag);
    end
  endtask

  initial begin
    vecs[0] = mk(16'h1234, 4'b0000, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66);
    vecs[1] = mk(16'h0050, 4'b0000, 1'b1, 7'h00, 7'h00, 7'h6D, 7'h3F);
    vecs[2] = mk(16'hABCD, 4'b0000, 1'b0, 7'h77, 7'h7C, 7'h39, 7'h5E);
    vecs[3] = mk(16'h89EF, 4'b0101, 1'b0, 7'h7F, 7'h6F, 7'h79, 7'h71);
    vecs[4] = mk(16'h0000, 4'b1010, 1'b1, 7'h00, 7'h00, 7'h00, 7'h3F);
    vecs[5] = mk(16'h0567, 4'b0000, 1'b1, 7'h00, 7'h6D, 7'h7D, 7'h07);
    vecs[6] = mk(16'h0000, 4'b0000, 1'b0, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    vecs[7] = mk(16'h1000, 4'b0000, 1'b1, 7'h06, 7'h3F, 7'h3F, 7'h3F);
    vz      = vecs[6];
    v1111   = mk(16'h1111, 4'b0000, 1'b0, 7'h06, 7'h06, 7'h06, 7'h06);

    rst_n    = 1'b1;
    enable   = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    dp_in    = 4'b0000;
    blank_lz = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1 cmp("reset_async", outs(), 13'h0000);
    repeat (3) @(negedge clk);
    cmp("reset_hold", outs(), 13'h0000);
    rst_n = 1'b1;

    // First frame after release shows zeros, digit 0 first
    check_frame(vz, "rst_frame", 1'b0, vz, 0);

    // Table of display vectors
    for (int i = 0; i < 8; i++) begin
      load_and_sync(vecs[i], $sformatf("vec%0d", i));
      check_frame(vecs[i], $sformatf("vec%0d", i), 1'b0, vz, 0);
    end

    // Mid-frame load must not tear the frame in progress
    load_and_sync(v1111, "tear");
    check_frame(v1111, "tear_pre", 1'b0, vz, 0);
    check_frame(v1111, "tear_hold", 1'b1, vecs[2], 6);
    check_frame(vecs[2], "tear_post", 1'b0, vz, 0);

    // Load coinciding with the wrap edge goes straight to the next frame
    check_frame(vecs[2], "wrap_old", 1'b1, vecs[0], 14);
    check_frame(vecs[0], "wrap_new", 1'b0, vz, 0);

    // Enable pause in the middle of digit 2, with a load while paused
    load_and_sync(vecs[3], "pause");
    check_frame(vecs[3], "pause_full", 1'b0, vz, 0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      cmp($sformatf("pause_pre_c%0d", j), outs(), exp_digit(vecs[3], j / 4, 1'b0));
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cmp($sformatf("pause_off_c%0d", k), outs(), 13'h0000);
      if (k == 3) drive(vecs[6]);
      if (k == 4) load = 1'b0;
    end
    enable = 1'b1;
    for (int m = 0; m < 6; m++) begin
      @(negedge clk);
      cmp($sformatf("pause_resume_c%0d", m), outs(),
          exp_digit(vecs[3], (m < 2) ? 2 : 3, (m == 5)));
    end
    check_frame(vecs[6], "pause_new", 1'b0, vz, 0);

    // Reset asserted while digit 2 is showing
    load_and_sync(vecs[0], "mrst");
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      cmp($sformatf("mrst_pre_c%0d", j), outs(), exp_digit(vecs[0], j / 4, 1'b0));
    end
    #1 rst_n = 1'b0;
    #1 cmp("mrst_async", outs(), 13'h0000);
    repeat (2) @(negedge clk);
    cmp("mrst_hold", outs(), 13'h0000);
    rst_n = 1'b1;
    check_frame(vz, "mrst_after0", 1'b0, vz, 0);
    check_frame(vz, "mrst_after1", 1'b0, vz, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
